// File: rtl/axil_cfg_master.sv
// rtl/axil_cfg_master.sv - AXI4-Lite initiator for single-beat register commands
// One transaction in flight; response carries resp, read data and latency.
module axil_cfg_master #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [CNT_WIDTH-1:0]  rsp_cycles,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  we_q, we_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  aw_hs, w_hs;

  // Saturating latency count; all-ones sticks.
  assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  assign m_axil_awvalid = (state_q == S_WR_ADDR) && !aw_done_q;
  assign m_axil_wvalid  = (state_q == S_WR_ADDR) && !w_done_q;
  assign m_axil_bready  = (state_q == S_WR_RESP);
  assign m_axil_arvalid = (state_q == S_RD_ADDR);
  assign m_axil_rready  = (state_q == S_RD_DATA);
  assign cmd_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RSP);

  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs  = m_axil_wvalid && m_axil_wready;

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign rsp_we        = we_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_cycles    = cnt_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          we_d      = cmd_we;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = '0;
          state_d   = cmd_we ? S_WR_ADDR : S_RD_ADDR;
        end
      end
      S_WR_ADDR: begin
        cnt_d = cnt_inc;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        cnt_d = cnt_inc;
        if (m_axil_bvalid) begin
          resp_d  = m_axil_bresp;
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      S_RD_ADDR: begin
        cnt_d = cnt_inc;
        if (m_axil_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        cnt_d = cnt_inc;
        if (m_axil_rvalid) begin
          rdata_d = m_axil_rdata;
          resp_d  = m_axil_rresp;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// tb/tb_axil_cfg_master.sv - directed self-checking bench for axil_cfg_master
module tb_axil_cfg_master;
  localparam int AW = 40;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [CW-1:0] rsp_cycles;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axil_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
    .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one cycle; on return we are in cycle N+1.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready});
    end
    tests++;
    if ({rsp_we, rsp_rdata, rsp_resp, rsp_cycles, awaddr, wdata, wstrb} !== '0) begin
      fails++;
      $display("FAIL reset_data: got rdata=%h resp=%h cyc=%h awaddr=%h expected all zero",
               rsp_rdata, rsp_resp, rsp_cycles, awaddr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_basic();
    awready = 1'b1; wready = 1'b1;
    issue(1'b1, 40'h00_0000_0040, 32'hDEAD_BEEF, 4'hF);
    tests++;
    if ({awvalid, wvalid, cmd_ready, bready, arvalid} !== 5'b11000 || awaddr !== 40'h40 ||
        wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF || awprot !== 3'b000) begin
      fails++;
      $display("FAIL wr_n1: got v=%b addr=%h data=%h strb=%h prot=%b expected v=11000 addr=40 data=deadbeef strb=f prot=000",
               {awvalid, wvalid, cmd_ready, bready, arvalid}, awaddr, wdata, wstrb, awprot);
    end
    tick();
    tests++;
    if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
      fails++;
      $display("FAIL wr_n2: got %b expected 0010", {awvalid, wvalid, bready, rsp_valid});
    end
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 ||
        rsp_cycles !== 16'd2 || rsp_we !== 1'b1 || bready !== 1'b0) begin
      fails++;
      $display("FAIL wr_rsp: got v=%b resp=%b rdata=%h cyc=%0d we=%b bready=%b expected v=1 resp=00 rdata=0 cyc=2 we=1 bready=0",
               rsp_valid, rsp_resp, rsp_rdata, rsp_cycles, rsp_we, bready);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL wr_idle: got cmd_ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_skewed_write();
    logic bad = 1'b0;
    awready = 1'b1; wready = 1'b0;
    issue(1'b1, 40'h12_3456_7893, 32'h0BAD_F00D, 4'h0);
    tests++;
    if ({awvalid, wvalid} !== 2'b11 || awaddr !== 40'h12_3456_7893 || wstrb !== 4'h0) begin
      fails++;
      $display("FAIL skew_n1: got v=%b addr=%h strb=%h expected v=11 addr=1234567893 strb=0",
               {awvalid, wvalid}, awaddr, wstrb);
    end
    for (int i = 2; i <= 6; i++) begin
      tick();
      if ({awvalid, wvalid, bready} !== 3'b010 || wdata !== 32'h0BAD_F00D) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL skew_hold: got v=%b data=%h expected v=010 data=0badf00d",
               {awvalid, wvalid, bready}, wdata);
    end
    wready = 1'b1;
    tick();
    wready = 1'b0;
    tests++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      fails++;
      $display("FAIL skew_bready: got %b expected 001", {awvalid, wvalid, bready});
    end
    bvalid = 1'b1; bresp = 2'b01;
    tick();
    bvalid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_cycles !== 16'd7 || rsp_resp !== 2'b01) begin
      fails++;
      $display("FAIL skew_rsp: got v=%b cyc=%0d resp=%b expected v=1 cyc=7 resp=01",
               rsp_valid, rsp_cycles, rsp_resp);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_read_backpressure();
    logic bad = 1'b0;
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b11;
    issue(1'b0, 40'h00_0000_0010, 32'hFFFF_FFFF, 4'hF);
    tests++;
    if ({arvalid, awvalid, wvalid, rready} !== 4'b1000 || araddr !== 40'h10 || arprot !== 3'b000) begin
      fails++;
      $display("FAIL rd_n1: got v=%b addr=%h prot=%b expected v=1000 addr=10 prot=000",
               {arvalid, awvalid, wvalid, rready}, araddr, arprot);
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      if ({arvalid, rready} !== 2'b10 || araddr !== 40'h10) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL rd_hold: got v=%b addr=%h expected v=10 addr=10", {arvalid, rready}, araddr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    tests++;
    if ({arvalid, rready} !== 2'b01) begin
      fails++;
      $display("FAIL rd_rready: got %b expected 01", {arvalid, rready});
    end
    rdata = 32'h1234_5678; rresp = 2'b10;
    tick();
    rvalid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_resp !== 2'b10 ||
        rsp_cycles !== 16'd5 || rsp_we !== 1'b0) begin
      fails++;
      $display("FAIL rd_rsp: got v=%b rdata=%h resp=%b cyc=%0d we=%b expected v=1 rdata=12345678 resp=10 cyc=5 we=0",
               rsp_valid, rsp_rdata, rsp_resp, rsp_cycles, rsp_we);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic bad = 1'b0;
    arready = 1'b1;
    issue(1'b0, 40'h00_0000_0020, 32'h0, 4'h0);
    tick();
    rvalid = 1'b1; rdata = 32'hA5A5_0001; rresp = 2'b00;
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    arready = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 40'h00_0000_0080;
    cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'h3;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0001 || rsp_cycles !== 16'd2 ||
          rsp_resp !== 2'b00 || cmd_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL stall_stable: got v=%b rdata=%h cyc=%0d cmd_ready=%b expected v=1 rdata=a5a50001 cyc=2 cmd_ready=0",
               rsp_valid, rsp_rdata, rsp_cycles, cmd_ready);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready: got cmd_ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
    awready = 1'b1; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tests++;
    if ({awvalid, wvalid, cmd_ready} !== 3'b110 || awaddr !== 40'h80 || wstrb !== 4'h3) begin
      fails++;
      $display("FAIL b2b_accept: got v=%b addr=%h strb=%h expected v=110 addr=80 strb=3",
               {awvalid, wvalid, cmd_ready}, awaddr, wstrb);
    end
    tick();
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_cycles !== 16'd2 || rsp_we !== 1'b1 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL b2b_rsp: got v=%b cyc=%0d we=%b rdata=%h expected v=1 cyc=2 we=1 rdata=0",
               rsp_valid, rsp_cycles, rsp_we, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic bad = 1'b0;
    awready = 1'b0; wready = 1'b0;
    issue(1'b1, 40'h00_0000_0100, 32'h1111_2222, 4'hF);
    tests++;
    if (awvalid !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: got awvalid=%b expected 1", awvalid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0000001) begin
      fails++;
      $display("FAIL rstmid_post: got %b expected 0000001",
               {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready});
    end
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || awvalid !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
    end
    bvalid = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL rstmid_quiet: got rsp_valid=%b awvalid=%b cmd_ready=%b expected 0 0 1",
               rsp_valid, awvalid, cmd_ready);
    end
  endtask

  task automatic test_saturation();
    logic bad = 1'b0;
    arready = 1'b0;
    issue(1'b0, 40'hFF_0000_0004, 32'h0, 4'h0);
    for (int i = 0; i < 70000; i++) begin
      if (arvalid !== 1'b1 || rsp_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL sat_hold: got arvalid=%b rsp_valid=%b expected 1 0", arvalid, rsp_valid);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_cycles !== 16'hFFFF || rsp_rdata !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL sat_rsp: got v=%b cyc=%h rdata=%h expected v=1 cyc=ffff rdata=cafef00d",
               rsp_valid, rsp_cycles, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL sat_done: got cmd_ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    test_reset();
    test_write_basic();
    test_skewed_write();
    test_read_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_cfg_master.md
# axil_cfg_master

AXI4-Lite initiator that turns single-beat register commands into AXI4-Lite write and read transactions on the accelerator's `s_axil_*` configuration slave. It replaces DPI backdoor accesses to the controller configuration registers and RAM with real bus traffic, so configuration is exercised through the same path the host uses. It sits between a simple command/response port, driven by a bench or host bridge, and the accelerator's AXI-Lite slave. Exactly one transaction is in flight at a time.

## Interface
- `ADDR_WIDTH`, 40: AXI-Lite address width.
- `DATA_WIDTH`, 32: AXI-Lite data width.
- `STRB_WIDTH`, `DATA_WIDTH/8`: write strobe width.
- `CNT_WIDTH`, 16: latency counter width.

Ports:
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_addr` in `ADDR_WIDTH`; `cmd_wdata` in `DATA_WIDTH`; `cmd_wstrb` in `STRB_WIDTH`.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_we` out 1: echoes `cmd_we`.
- `rsp_rdata` out `DATA_WIDTH`: read data; 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP as returned by the slave.
- `rsp_cycles` out `CNT_WIDTH`: transaction latency.
- `m_axil_aw*`: `awaddr` out `ADDR_WIDTH`, `awprot` out 3, `awvalid` out 1, `awready` in 1.
- `m_axil_w*`: `wdata` out `DATA_WIDTH`, `wstrb` out `STRB_WIDTH`, `wvalid` out 1, `wready` in 1.
- `m_axil_b*`: `bresp` in 2, `bvalid` in 1, `bready` out 1.
- `m_axil_ar*`: `araddr` out `ADDR_WIDTH`, `arprot` out 3, `arvalid` out 1, `arready` in 1.
- `m_axil_r*`: `rdata` in `DATA_WIDTH`, `rresp` in 2, `rvalid` in 1, `rready` out 1.

## Operation
**States:** IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP.

**IDLE**
- `cmd_ready`=1.
- On a `cmd_valid` handshake: register addr, wdata, wstrb and we; clear the counter.
- Go to WR_ADDR if we=1, else RD_ADDR.

**WR_ADDR**
- `awvalid` and `wvalid` both rise on entry.
- Each drops independently in the cycle after its own handshake. Internal done flags `aw_done` and `w_done` track completion.
- When both are done (including both in the same cycle), go to WR_RESP.

**WR_RESP**
- `bready`=1.
- On the `bvalid` handshake: capture `bresp`, set rdata=0, go to RSP.

**RD_ADDR**
- `arvalid`=1.
- On the `arready` handshake, go to RD_DATA.

**RD_DATA**
- `rready`=1.
- On the `rvalid` handshake: capture `rdata` and `rresp`, go to RSP.

**RSP**
- `rsp_valid`=1; all response fields stay stable.
- On `rsp_ready`, return to IDLE.

**Common rules**
- `awprot` and `arprot` are constant 3'b000.
- Address, data and strobe are driven from registers and stay stable while the corresponding valid is high.
- Addresses pass unaligned bits through unchanged. `wstrb`=0 is passed through.
- Valids never drop before their handshake. Valids are never asserted outside their own state.
- Latency counter: counts 1 in the first cycle of WR_ADDR/RD_ADDR and increments every cycle up to and including the B/R handshake cycle. It saturates at all-ones and is frozen in RSP.

**Reset**
- Every output is 0 except `cmd_ready`=1 (IDLE); state is IDLE.
- A reset asserted mid-transaction drops all valids and readies at that edge and discards the transaction; no response is produced.

## Timing
- Command accepted at edge N. The first AXI valid is high in cycle N+1, and is combinational from the state only.
- Write: best case (awready=wready=1, bvalid in the following cycle): B handshake at the end of cycle N+2, `rsp_valid` in cycle N+3, `rsp_cycles`=2.
- Read: best case (arready=1, rvalid in the following cycle): `rsp_valid` in cycle N+3, `rsp_cycles`=2.
- `cmd_ready` is low from N+1 until the cycle after the `rsp_ready` handshake. Back-to-back commands are therefore spaced by at least 4 cycles.
- An asserted `bvalid`/`rvalid` is ignored outside WR_RESP/RD_DATA. `bready`/`rready` are 0 there.

## Test plan
- **Write, always-ready slave.** Write addr=0x0000_0040, data=0xDEAD_BEEF, strb=0xF, bresp=0.
  - AW and W handshake together in N+1.
  - `rsp_valid` in N+3 with resp=0, rdata=0, cycles=2.
- **Skewed write.** wready is delayed 5 cycles after awready.
  - `awvalid` drops after 1 cycle; `wvalid` is held for 6 cycles with stable data.
  - `bready` is only asserted afterwards; cycles=7 for a 1-cycle B.
- **Read with backpressure.** Read addr=0x0000_0010; arready is delayed 3 cycles, then rvalid follows with rdata=0x1234_5678, rresp=2'b10.
  - Response carries rdata 0x1234_5678, resp 2'b10, cycles=5.
- **Response stall and back-to-back.** `rsp_ready` is held low for 4 cycles.
  - Response fields stay stable and `cmd_ready`=0 throughout.
  - A second queued command is accepted the cycle after the `rsp_ready` handshake.
- **Reset mid-transaction.** Assert `rst` while in WR_ADDR with awvalid=1 and awready=0.
  - Next cycle: all valids are 0, `cmd_ready`=1, and no `rsp_valid` ever appears.
- **Saturation.** Hold arready=0 for 70000 cycles.
  - `rsp_cycles`=0xFFFF; the response still completes normally.
